// File: rtl/pipe_hazard_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
package pipe_hazard_pkg;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    // Slot dst field is sized for the widest supported register address.
    localparam int unsigned SLOT_AW = 8;

    localparam int unsigned STAGE_EX   = 0;
    localparam int unsigned STAGE_MEM  = 1;
    localparam int unsigned STAGE_WB   = 2;
    localparam int unsigned NUM_STAGES = 3;

    typedef struct packed {
        logic               valid;
        logic               regwrite;
        logic               memread;
        logic [SLOT_AW-1:0] dst;
    } slot_t;

    function automatic logic slot_is_producer(slot_t s);
        return s.valid && s.regwrite && (s.dst != '0);
    endfunction

    function automatic logic slot_matches(slot_t s, logic use_src, logic [SLOT_AW-1:0] src);
        return slot_is_producer(s) && use_src && (s.dst == src);
    endfunction

endpackage

// File: rtl/hazard_slot_reg.sv
// One shadow slot of destination-register info; squash loads an invalid slot.
module hazard_slot_reg
    import pipe_hazard_pkg::*;
(
    input  logic  i_clk,
    input  logic  i_rst,
    input  logic  i_load,
    input  logic  i_squash,
    input  slot_t i_slot,
    output slot_t o_slot
);

    slot_t r_slot;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_slot <= '0;
        end else if (i_squash) begin
            r_slot <= '0;
        end else if (i_load) begin
            r_slot <= i_slot;
        end
    end

    assign o_slot = r_slot;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard detection, flush sequencing and EX forwarding selects for a 5-stage MIPS pipe.
// Define PIPE_HAZARD_FWD_EN to enable forwarding; otherwise every RAW hazard stalls.
module pipe_hazard_ctrl
    import pipe_hazard_pkg::*;
#(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_use_rs_i,
    input  logic              id_use_rt_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic [REG_AW-1:0] id_dst_i,
    input  logic              mem_br_taken_i,
    output logic              pc_write_o,
    output logic              ifid_write_o,
    output logic              ifid_flush_o,
    output logic              idex_bubble_o,
    output logic              exmem_flush_o,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    slot_t              w_slot [NUM_STAGES];
    slot_t              w_id_slot;
    logic [SLOT_AW-1:0] w_rs;
    logic [SLOT_AW-1:0] w_rt;
    logic               w_ex_hit;
    logic               w_mem_hit;
    logic               w_stall_raw;
    logic               w_stall;
    logic               w_flush;
    logic               w_ex_load;
    logic               w_unused;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic [CNT_W-1:0]   r_flush_cnt;

    assign w_rs = SLOT_AW'(id_rs_i);
    assign w_rt = SLOT_AW'(id_rt_i);

    assign w_id_slot = '{valid:    1'b1,
                         regwrite: id_regwrite_i,
                         memread:  id_memread_i,
                         dst:      SLOT_AW'(id_dst_i)};

    assign w_ex_hit  = slot_matches(w_slot[STAGE_EX], id_use_rs_i, w_rs) ||
                       slot_matches(w_slot[STAGE_EX], id_use_rt_i, w_rt);
    assign w_mem_hit = slot_matches(w_slot[STAGE_MEM], id_use_rs_i, w_rs) ||
                       slot_matches(w_slot[STAGE_MEM], id_use_rt_i, w_rt);

`ifdef PIPE_HAZARD_FWD_EN
    assign w_stall_raw = id_valid_i && w_ex_hit && w_slot[STAGE_EX].memread;
`else
    assign w_stall_raw = id_valid_i && (w_ex_hit || w_mem_hit);
`endif

    // Flush wins: a stall that coincides with a flush is neither applied nor counted.
    assign w_flush   = mem_br_taken_i;
    assign w_stall   = w_stall_raw && !w_flush;
    assign w_ex_load = id_valid_i && !w_stall && !w_flush;

    assign pc_write_o    = !w_stall;
    assign ifid_write_o  = !w_stall;
    assign ifid_flush_o  = w_flush;
    assign idex_bubble_o = w_stall || w_flush;
    assign exmem_flush_o = w_flush;

    hazard_slot_reg u_slot_ex (
        .i_clk    (clk_i),
        .i_rst    (rst_i),
        .i_load   (1'b1),
        .i_squash (!w_ex_load),
        .i_slot   (w_id_slot),
        .o_slot   (w_slot[STAGE_EX])
    );

    hazard_slot_reg u_slot_mem (
        .i_clk    (clk_i),
        .i_rst    (rst_i),
        .i_load   (1'b1),
        .i_squash (w_flush),
        .i_slot   (w_slot[STAGE_EX]),
        .o_slot   (w_slot[STAGE_MEM])
    );

    hazard_slot_reg u_slot_wb (
        .i_clk    (clk_i),
        .i_rst    (rst_i),
        .i_load   (1'b1),
        .i_squash (1'b0),
        .i_slot   (w_slot[STAGE_MEM]),
        .o_slot   (w_slot[STAGE_WB])
    );

    // WB is tracked for completeness but never produces a hazard.
    assign w_unused = ^{w_slot[STAGE_WB], w_slot[STAGE_MEM].memread, w_slot[STAGE_EX].memread,
                        w_mem_hit};

`ifdef PIPE_HAZARD_FWD_EN
    logic [1:0] r_fwd_a;
    logic [1:0] r_fwd_b;

    function automatic logic [1:0] fwd_sel(slot_t ex, slot_t mem, logic use_src,
                                           logic [SLOT_AW-1:0] src);
        if (slot_matches(ex, use_src, src) && !ex.memread) begin
            return FWD_EXMEM;
        end else if (slot_matches(mem, use_src, src)) begin
            return FWD_MEMWB;
        end
        return FWD_RF;
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_fwd_a <= FWD_RF;
            r_fwd_b <= FWD_RF;
        end else if (w_ex_load) begin
            r_fwd_a <= fwd_sel(w_slot[STAGE_EX], w_slot[STAGE_MEM], id_use_rs_i, w_rs);
            r_fwd_b <= fwd_sel(w_slot[STAGE_EX], w_slot[STAGE_MEM], id_use_rt_i, w_rt);
        end else begin
            r_fwd_a <= FWD_RF;
            r_fwd_b <= FWD_RF;
        end
    end

    assign fwd_a_o = r_fwd_a;
    assign fwd_b_o = r_fwd_b;
`else
    assign fwd_a_o = FWD_RF;
    assign fwd_b_o = FWD_RF;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (both PIPE_HAZARD_FWD_EN builds).
module tb_pipe_hazard_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        id_valid_i;
    logic [4:0]  id_rs_i;
    logic [4:0]  id_rt_i;
    logic        id_use_rs_i;
    logic        id_use_rt_i;
    logic        id_regwrite_i;
    logic        id_memread_i;
    logic [4:0]  id_dst_i;
    logic        mem_br_taken_i;
    logic        pc_write_o;
    logic        ifid_write_o;
    logic        ifid_flush_o;
    logic        idex_bubble_o;
    logic        exmem_flush_o;
    logic [1:0]  fwd_a_o;
    logic [1:0]  fwd_b_o;
    logic [15:0] stall_cnt_o;
    logic [15:0] flush_cnt_o;

    int          checks = 0;
    int          failures = 0;
    int unsigned exp_stall = 0;
    int unsigned exp_flush = 0;

`ifdef PIPE_HAZARD_FWD_EN
    localparam logic PMR = 1'b1;
`else
    localparam logic PMR = 1'b0;
`endif

    pipe_hazard_ctrl #(.REG_AW(5), .CNT_W(16)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .id_valid_i     (id_valid_i),
        .id_rs_i        (id_rs_i),
        .id_rt_i        (id_rt_i),
        .id_use_rs_i    (id_use_rs_i),
        .id_use_rt_i    (id_use_rt_i),
        .id_regwrite_i  (id_regwrite_i),
        .id_memread_i   (id_memread_i),
        .id_dst_i       (id_dst_i),
        .mem_br_taken_i (mem_br_taken_i),
        .pc_write_o     (pc_write_o),
        .ifid_write_o   (ifid_write_o),
        .ifid_flush_o   (ifid_flush_o),
        .idex_bubble_o  (idex_bubble_o),
        .exmem_flush_o  (exmem_flush_o),
        .fwd_a_o        (fwd_a_o),
        .fwd_b_o        (fwd_b_o),
        .stall_cnt_o    (stall_cnt_o),
        .flush_cnt_o    (flush_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic urs, input logic urt, input logic rw, input logic mr,
                          input logic [4:0] dst);
        id_valid_i    = v;
        id_rs_i       = rs;
        id_rt_i       = rt;
        id_use_rs_i   = urs;
        id_use_rt_i   = urt;
        id_regwrite_i = rw;
        id_memread_i  = mr;
        id_dst_i      = dst;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        mem_br_taken_i = 1'b0;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        mem_br_taken_i = 1'b0;
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        #2;
        checks++; if (pc_write_o !== 1'b1) begin failures++; $display("FAIL reset_pc_write got=%0b exp=1", pc_write_o); end
        checks++; if (ifid_write_o !== 1'b1) begin failures++; $display("FAIL reset_ifid_write got=%0b exp=1", ifid_write_o); end
        checks++; if ({ifid_flush_o, idex_bubble_o, exmem_flush_o} !== 3'b000) begin failures++; $display("FAIL reset_flush_bubble got=%b exp=000", {ifid_flush_o, idex_bubble_o, exmem_flush_o}); end
        checks++; if ({fwd_a_o, fwd_b_o} !== 4'b0000) begin failures++; $display("FAIL reset_fwd got=%b exp=0000", {fwd_a_o, fwd_b_o}); end
        checks++; if (stall_cnt_o !== 16'd0 || flush_cnt_o !== 16'd0) begin failures++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", stall_cnt_o, flush_cnt_o); end
        @(negedge clk_i);
        rst_i = 1'b0;
        tick();
    endtask

`ifdef PIPE_HAZARD_FWD_EN
    task automatic test_load_use();
        idle(3);
        set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2);  // lw $2,0($1)
        #1;
        checks++; if (pc_write_o !== 1'b1) begin failures++; $display("FAIL lu_lw_pc_write got=%0b exp=1", pc_write_o); end
        tick();
        set_id(1'b1, 5'd2, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3);  // add $3,$2,$4
        #1;
        checks++; if ({pc_write_o, ifid_write_o, idex_bubble_o} !== 3'b001) begin failures++; $display("FAIL lu_stall got=%b exp=001", {pc_write_o, ifid_write_o, idex_bubble_o}); end
        tick();
        exp_stall++;
        checks++; if ({pc_write_o, idex_bubble_o} !== 2'b10) begin failures++; $display("FAIL lu_release got=%b exp=10", {pc_write_o, idex_bubble_o}); end
        tick();
        checks++; if (fwd_a_o !== 2'b01 || fwd_b_o !== 2'b00) begin failures++; $display("FAIL lu_fwd got=%b/%b exp=01/00", fwd_a_o, fwd_b_o); end
        checks++; if (stall_cnt_o !== 16'(exp_stall)) begin failures++; $display("FAIL lu_stall_cnt got=%0d exp=%0d", stall_cnt_o, exp_stall); end
    endtask

    task automatic test_fwd_exmem();
        idle(3);
        set_id(1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd2);  // add $2,$1,$1
        tick();
        set_id(1'b1, 5'd4, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3);  // sub $3,$4,$2
        #1;
        checks++; if (pc_write_o !== 1'b1 || idex_bubble_o !== 1'b0) begin failures++; $display("FAIL exmem_no_stall got=%b exp=10", {pc_write_o, idex_bubble_o}); end
        tick();
        checks++; if (fwd_a_o !== 2'b00 || fwd_b_o !== 2'b10) begin failures++; $display("FAIL exmem_fwd got=%b/%b exp=00/10", fwd_a_o, fwd_b_o); end
    endtask

    task automatic test_fwd_memwb();
        idle(3);
        set_id(1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd2);  // add $2,$1,$1
        tick();
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);  // nop
        tick();
        set_id(1'b1, 5'd2, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd5);  // or $5,$2,$2
        tick();
        checks++; if (fwd_a_o !== 2'b01 || fwd_b_o !== 2'b01) begin failures++; $display("FAIL memwb_fwd got=%b/%b exp=01/01", fwd_a_o, fwd_b_o); end
    endtask
`else
    task automatic test_raw_stall();
        idle(3);
        set_id(1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd2);  // add $2,$1,$1
        #1;
        checks++; if (pc_write_o !== 1'b1) begin failures++; $display("FAIL raw_add_pc_write got=%0b exp=1", pc_write_o); end
        tick();
        set_id(1'b1, 5'd2, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3);  // sub $3,$2,$2
        #1;
        checks++; if ({pc_write_o, ifid_write_o, idex_bubble_o} !== 3'b001) begin failures++; $display("FAIL raw_stall1 got=%b exp=001", {pc_write_o, ifid_write_o, idex_bubble_o}); end
        tick();
        exp_stall++;
        checks++; if ({pc_write_o, idex_bubble_o} !== 2'b01) begin failures++; $display("FAIL raw_stall2 got=%b exp=01", {pc_write_o, idex_bubble_o}); end
        tick();
        exp_stall++;
        checks++; if ({pc_write_o, idex_bubble_o} !== 2'b10) begin failures++; $display("FAIL raw_release got=%b exp=10", {pc_write_o, idex_bubble_o}); end
        checks++; if (stall_cnt_o !== 16'(exp_stall)) begin failures++; $display("FAIL raw_stall_cnt got=%0d exp=%0d", stall_cnt_o, exp_stall); end
        tick();
        checks++; if (fwd_a_o !== 2'b00 || fwd_b_o !== 2'b00) begin failures++; $display("FAIL raw_fwd got=%b/%b exp=00/00", fwd_a_o, fwd_b_o); end
    endtask
`endif

    task automatic test_dst_zero();
        idle(3);
        set_id(1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 1'b1, PMR, 5'd0);  // writes $0
        tick();
        set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3);  // add $3,$0,$0
        #1;
        checks++; if (pc_write_o !== 1'b1 || idex_bubble_o !== 1'b0) begin failures++; $display("FAIL dst0_no_stall got=%b exp=10", {pc_write_o, idex_bubble_o}); end
        tick();
        checks++; if (fwd_a_o !== 2'b00 || fwd_b_o !== 2'b00) begin failures++; $display("FAIL dst0_fwd got=%b/%b exp=00/00", fwd_a_o, fwd_b_o); end
    endtask

    task automatic test_use_gating();
        idle(3);
        set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, PMR, 5'd2);
        tick();
        set_id(1'b1, 5'd2, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3);  // fields match, not read
        #1;
        checks++; if (pc_write_o !== 1'b1) begin failures++; $display("FAIL gate_unused_src got=%0b exp=1", pc_write_o); end
        set_id(1'b0, 5'd2, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3);  // flushed bubble in ID
        #1;
        checks++; if (pc_write_o !== 1'b1) begin failures++; $display("FAIL gate_invalid_id got=%0b exp=1", pc_write_o); end
        set_id(1'b1, 5'd0, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);  // store data on rt
        #1;
        checks++; if (pc_write_o !== 1'b0) begin failures++; $display("FAIL gate_rt_store got=%0b exp=0", pc_write_o); end
    endtask

    task automatic test_flush();
        idle(3);
        set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2);  // lw $2,0($1)
        tick();
        set_id(1'b1, 5'd2, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3);
        mem_br_taken_i = 1'b1;
        #1;
        checks++; if ({ifid_flush_o, idex_bubble_o, exmem_flush_o, pc_write_o, ifid_write_o} !== 5'b11111) begin failures++; $display("FAIL flush_outputs got=%b exp=11111", {ifid_flush_o, idex_bubble_o, exmem_flush_o, pc_write_o, ifid_write_o}); end
        tick();
        mem_br_taken_i = 1'b0;
        exp_flush++;
        #1;
        checks++; if (flush_cnt_o !== 16'(exp_flush)) begin failures++; $display("FAIL flush_cnt got=%0d exp=%0d", flush_cnt_o, exp_flush); end
        checks++; if (stall_cnt_o !== 16'(exp_stall)) begin failures++; $display("FAIL flush_stall_cnt got=%0d exp=%0d", stall_cnt_o, exp_stall); end
        checks++; if ({pc_write_o, ifid_flush_o, exmem_flush_o} !== 3'b100) begin failures++; $display("FAIL flush_squashed got=%b exp=100", {pc_write_o, ifid_flush_o, exmem_flush_o}); end
    endtask

    task automatic test_reset_mid_stall();
        idle(3);
        set_id(1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 1'b1, PMR, 5'd2);
        tick();
        set_id(1'b1, 5'd2, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3);  // sub/add $3,$2,$2
`ifndef PIPE_HAZARD_FWD_EN
        tick();
`endif
        #1;
        checks++; if (pc_write_o !== 1'b0) begin failures++; $display("FAIL rst_pre_stall got=%0b exp=0", pc_write_o); end
        rst_i = 1'b1;
        #1;
        exp_stall = 0;
        exp_flush = 0;
        checks++; if ({pc_write_o, ifid_write_o, idex_bubble_o} !== 3'b110) begin failures++; $display("FAIL rst_mid_outputs got=%b exp=110", {pc_write_o, ifid_write_o, idex_bubble_o}); end
        checks++; if (stall_cnt_o !== 16'd0 || flush_cnt_o !== 16'd0) begin failures++; $display("FAIL rst_mid_counters got=%0d/%0d exp=0/0", stall_cnt_o, flush_cnt_o); end
        #1;
        rst_i = 1'b0;
        tick();
        set_id(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd5);  // reads $3
        #1;
`ifdef PIPE_HAZARD_FWD_EN
        checks++; if (pc_write_o !== 1'b1) begin failures++; $display("FAIL rst_after_no_stall got=%0b exp=1", pc_write_o); end
        tick();
        checks++; if (fwd_a_o !== 2'b10) begin failures++; $display("FAIL rst_after_fwd got=%b exp=10", fwd_a_o); end
`else
        checks++; if (pc_write_o !== 1'b0) begin failures++; $display("FAIL rst_after_stall got=%0b exp=0", pc_write_o); end
`endif
    endtask

    initial begin
        test_reset();
`ifdef PIPE_HAZARD_FWD_EN
        test_load_use();
        test_fwd_exmem();
        test_fwd_memwb();
`else
        test_raw_stall();
`endif
        test_dst_zero();
        test_use_gating();
        test_flush();
        test_reset_mid_stall();
        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and forwarding controller for the 5-stage pipelined MIPS CPU. It keeps a shadow copy of the destination-register information for the EX, MEM and WB stages. From that copy it generates:
- PC and IF/ID write enables, ID/EX bubble insertion and branch-flush strobes;
- EX-stage operand forwarding selects.

It sits beside the pipeline registers. It sequences them but does not carry datapath values.

## Interface
Parameters:
- `REG_AW`, default 5: register-address width.
- `CNT_W`, default 16: width of the stall and flush statistic counters.

Ports:
- `clk_i`  in  1: clock. All state updates on the rising edge.
- `rst_i`  in  1: reset. Asynchronous, active-high.
- `id_valid_i`  in  1: IF/ID holds a real instruction, not a flushed bubble.
- `id_rs_i`  in  REG_AW: rs field of the ID instruction.
- `id_rt_i`  in  REG_AW: rt field of the ID instruction.
- `id_use_rs_i`  in  1: the ID instruction reads rs.
- `id_use_rt_i`  in  1: the ID instruction reads rt, as a register operand or as store data.
- `id_regwrite_i`  in  1: RegWrite for the ID instruction.
- `id_memread_i`  in  1: MemRead for the ID instruction.
- `id_dst_i`  in  REG_AW: destination register after RegDst resolution in ID.
- `mem_br_taken_i`  in  1: a branch resolved as taken in MEM this cycle.
- `pc_write_o`  out  1: PC load enable.
- `ifid_write_o`  out  1: IF/ID load enable.
- `ifid_flush_o`  out  1: IF/ID loads a bubble.
- `idex_bubble_o`  out  1: ID/EX loads zero control signals.
- `exmem_flush_o`  out  1: EX/MEM loads zero control signals.
- `fwd_a_o`  out  2: EX source-A select.
- `fwd_b_o`  out  2: EX source-B select.
- `stall_cnt_o`  out  CNT_W: count of stall cycles, saturating.
- `flush_cnt_o`  out  CNT_W: count of flush events, saturating.

## Operation
- Each shadow slot (EX, MEM, WB) holds {valid, regwrite, memread, dst}.
- A slot is a producer when valid && regwrite && dst != 0.
- Load-use stall: the EX slot is a producer with memread, and its dst equals an used ID source (id_use_rs_i && id_rs_i, or id_use_rt_i && id_rt_i). The ID instruction must be valid.
- While stalled:
  - pc_write_o = 0 and ifid_write_o = 0;
  - idex_bubble_o = 1;
  - the EX slot loads invalid at the next edge.
- Flush: mem_br_taken_i = 1 drives ifid_flush_o, idex_bubble_o and exmem_flush_o all to 1, and pc_write_o to 1.
  - At the next edge the EX and MEM slots load invalid.
  - Flush has priority over stall. A stall coinciding with a flush is not counted.
- Slot shift on every edge:
  - WB ← MEM.
  - MEM ← EX, or invalid on flush.
  - EX ← ID info when id_valid_i && !stall && !flush; otherwise invalid.
- Forwarding is computed for the instruction moving from ID to EX and registered into fwd_a_o / fwd_b_o:
  - `FWD_EXMEM` (2'b10): the current EX slot is a non-load producer matching the source.
  - `FWD_MEMWB` (2'b01): the current MEM slot is a producer matching the source.
  - If both match, EX/MEM wins.
  - Otherwise `FWD_RF` (2'b00).
  - Bubbles load 00.
- fwd_b_o applies to rt whenever id_use_rt_i = 1. This covers the store-data path.
- The WB slot never causes a hazard. The register file writes before it reads within a cycle; this is an integration requirement.
- Counters:
  - stall_cnt_o increments on each cycle with a counted stall.
  - flush_cnt_o increments on each cycle with mem_br_taken_i = 1.
  - Both saturate at all ones.

## Timing
- Stall and flush outputs are combinational from the inputs and the registered slots, so there is zero-cycle latency. They must settle before the edge.
- fwd_a_o / fwd_b_o are registered and valid throughout the instruction's EX cycle, one edge after it left ID.
- Load-use costs exactly 1 bubble. A taken branch squashes exactly 3 instructions (IF/ID, ID/EX, EX/MEM).
- Reset, asynchronous:
  - all slots invalid, fwd_a_o = fwd_b_o = 00, counters 0;
  - with mem_br_taken_i = 0, pc_write_o = ifid_write_o = 1 and all flush/bubble outputs 0.
- Reset asserted mid-stall or mid-flush clears the state immediately. The first edge after release shifts normally.
- dst = 0 producers never stall or forward.

## Configuration
- `PIPE_HAZARD_FWD_EN` defined:
  - forwarding enabled as above;
  - only load-use stalls occur.
- Undefined:
  - fwd_a_o / fwd_b_o are tied 00;
  - stall whenever the EX or MEM slot is a producer (load or not) matching an used ID source;
  - stall cycles are counted identically.

## Structure
- Package `pipe_hazard_pkg` holds:
  - the `FWD_RF`, `FWD_MEMWB` and `FWD_EXMEM` constants;
  - the slot record type {valid, regwrite, memread, dst};
  - the stage indices.
- One sub-module, `hazard_slot_reg`: a single shadow slot with load, squash and async reset, instantiated three times.

## Test plan
- lw $2,0($1); add $3,$2,$4 with FWD_EN defined:
  - exactly 1 cycle with pc_write_o = 0 and idex_bubble_o = 1;
  - then fwd_a_o = 01 in the add's EX cycle;
  - stall_cnt_o = 1.
- add $2,$1,$1; sub $3,$4,$2: no stall; fwd_b_o = 10 in the sub's EX cycle.
- add $2,..; nop; or $5,$2,$2: fwd_a_o = fwd_b_o = 01.
- add $0,$1,$1; add $3,$0,$0: fwd 00, no stall.
- mem_br_taken_i pulsed for 1 cycle coincident with a load-use condition:
  - ifid_flush_o = idex_bubble_o = exmem_flush_o = 1 and pc_write_o = 1;
  - flush_cnt_o = 1 and stall_cnt_o unchanged.
- FWD_EN undefined, add $2,..; sub $3,$2,$2:
  - 2 stall cycles, then fwd 00;
  - rst_i asserted during the second stall cycle: outputs return to reset values immediately.
